// File: rtl/riscv_test_monitor.sv
// End-of-test checker: snoops rf writes, retirement and tohost stores, keeps a shadow
// register file and delivers a timeout-guarded pass/fail verdict with cycle/retire counts.
module riscv_test_monitor #(
  parameter int          XLEN           = 32,
  parameter int          NUM_CHECKS     = 4,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       retire,
  input  logic                       rf_we,
  input  logic [4:0]                 rf_waddr,
  input  logic [XLEN-1:0]            rf_wdata,
  input  logic                       mem_we,
  input  logic [31:0]                mem_addr,
  input  logic [XLEN-1:0]            mem_wdata,
  input  logic [NUM_CHECKS-1:0]      chk_en,
  input  logic [NUM_CHECKS*5-1:0]    chk_reg,
  input  logic [NUM_CHECKS*XLEN-1:0] chk_val,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [NUM_CHECKS-1:0]      mismatch_mask,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           retire_count
);

  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [XLEN-1:0]       shadow [32];
  logic [IDX_W-1:0]      chk_idx;

  logic                  tohost_hit, tohost_ok, tohost_bad;
  logic [CNT_W-1:0]      cyc_inc, ret_inc;
  logic                  timeout_hit, last_check;
  logic [NUM_CHECKS-1:0] slot_bad, mask_nxt;

  always_comb begin
    tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    tohost_ok   = tohost_hit && (mem_wdata == XLEN'(1));
    tohost_bad  = tohost_hit && (mem_wdata != XLEN'(1)) && (mem_wdata != '0);
    cyc_inc     = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
    ret_inc     = (retire_count == '1) ? retire_count : retire_count + 1'b1;
    timeout_hit = (cyc_inc == CNT_W'(TIMEOUT_CYCLES));
    last_check  = (chk_idx == IDX_W'(NUM_CHECKS - 1));
  end

  // Only the slot addressed by chk_idx can flag a mismatch in a given CHECK cycle.
  always_comb begin
    slot_bad = '0;
    for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
      if ((chk_idx == IDX_W'(i)) && chk_en[i] &&
          (shadow[chk_reg[5*i +: 5]] != chk_val[XLEN*i +: XLEN]))
        slot_bad[i] = 1'b1;
    end
    mask_nxt = mismatch_mask | slot_bad;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (tohost_ok)                      state_nxt = S_CHECK;
        else if (tohost_bad || timeout_hit) state_nxt = S_DONE;
      end
      S_CHECK: if (last_check) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= 2'd0;
      mismatch_mask <= '0;
      cycle_count   <= '0;
      retire_count  <= '0;
      chk_idx       <= '0;
      for (int unsigned r = 0; r < 32; r++) shadow[r] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_code     <= 2'd0;
            mismatch_mask <= '0;
            cycle_count   <= '0;
            retire_count  <= '0;
            chk_idx       <= '0;
            for (int unsigned r = 0; r < 32; r++) shadow[r] <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cyc_inc;
          if (retire) retire_count <= ret_inc;
          if (rf_we && (rf_waddr != 5'd0)) shadow[rf_waddr] <= rf_wdata;
          chk_idx <= '0;
          // A nonzero tohost store outranks a timeout landing in the same cycle.
          if (tohost_bad) begin
            done      <= 1'b1;
            fail_code <= 2'd2;
          end else if (!tohost_ok && timeout_hit) begin
            done      <= 1'b1;
            fail_code <= 2'd3;
          end
        end
        S_CHECK: begin
          mismatch_mask <= mask_nxt;
          chk_idx       <= chk_idx + 1'b1;
          if (last_check) begin
            chk_idx   <= '0;
            done      <= 1'b1;
            pass      <= (mask_nxt == '0);
            fail_code <= (mask_nxt != '0) ? 2'd1 : 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomized and directed bench for riscv_test_monitor against a behavioural model
// of the architectural register file, cycle/retire tallies and verdict rules.
module tb_riscv_test_monitor;
  localparam int          XLEN   = 32;
  localparam int          NC     = 4;
  localparam int          TO     = 50;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0, retire = 1'b0, rf_we = 1'b0, mem_we = 1'b0;
  logic [4:0]           rf_waddr = '0;
  logic [XLEN-1:0]      rf_wdata = '0, mem_wdata = '0;
  logic [31:0]          mem_addr = '0;
  logic [NC-1:0]        chk_en = '0;
  logic [NC*5-1:0]      chk_reg = '0;
  logic [NC*XLEN-1:0]   chk_val = '0;
  logic                 done, pass;
  logic [1:0]           fail_code;
  logic [NC-1:0]        mismatch_mask;
  logic [CNT_W-1:0]     cycle_count, retire_count;

  riscv_test_monitor #(
    .XLEN(XLEN), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .TOHOST_ADDR(TOHOST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .retire(retire),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .chk_en(chk_en), .chk_reg(chk_reg), .chk_val(chk_val),
    .done(done), .pass(pass), .fail_code(fail_code), .mismatch_mask(mismatch_mask),
    .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: architectural registers and tallies for the current run.
  logic [31:0] m_rf [32];
  int          m_cyc, m_ret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  // One RUN cycle of cpu activity; the model follows the architectural rules.
  task automatic cyc(input bit ret, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit mwe, input logic [31:0] ma, input logic [31:0] mwd, input bit st);
    retire = ret; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    mem_we = mwe; mem_addr = ma; mem_wdata = mwd; start = st;
    step();
    m_cyc++;
    if (ret) m_ret++;
    if (we && wa != 5'd0) m_rf[wa] = wd;
    retire = 0; rf_we = 0; mem_we = 0; start = 0;
  endtask

  function automatic logic [NC-1:0] exp_mask();
    logic [NC-1:0] m = '0;
    for (int i = 0; i < NC; i++)
      if (chk_en[i] && m_rf[chk_reg[5*i +: 5]] != chk_val[XLEN*i +: XLEN]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic start_run(input string tag);
    model_clear();
    start = 1;
    step();
    start = 0;
    check($sformatf("%s_start_done", tag), done, 0);
    check($sformatf("%s_start_cyc", tag), cycle_count, 0);
    check($sformatf("%s_start_ret", tag), retire_count, 0);
  endtask

  task automatic random_prog(input int n);
    for (int k = 0; k < n; k++) begin
      logic        hit = ($urandom_range(0, 3) == 0);
      logic [31:0] ma  = hit ? TOHOST : TOHOST + 32'(4 * $urandom_range(1, 100));
      logic [31:0] md  = hit ? 32'd0 : $urandom;
      cyc($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
          $urandom_range(0, 1), ma, md, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic random_slots(input bit corrupt);
    for (int i = 0; i < NC; i++) begin
      logic [4:0]  r = 5'($urandom_range(0, 31));
      logic [31:0] flip = (corrupt && $urandom_range(0, 1)) ? 32'd1 << $urandom_range(0, 31) : 32'd0;
      chk_en[i]              = ($urandom_range(0, 3) != 0);
      chk_reg[5*i +: 5]      = r;
      chk_val[XLEN*i +: XLEN] = m_rf[r] ^ flip;
    end
  endtask

  task automatic verdict(input string tag, input bit e_pass, input logic [1:0] e_code,
                         input logic [NC-1:0] e_mask);
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_pass", tag), pass, e_pass);
    check($sformatf("%s_code", tag), fail_code, e_code);
    check($sformatf("%s_mask", tag), mismatch_mask, e_mask);
    check($sformatf("%s_cyc", tag), cycle_count, m_cyc);
    check($sformatf("%s_ret", tag), retire_count, m_ret);
    repeat (3) step();
    check($sformatf("%s_hold_done", tag), done, 1);
    check($sformatf("%s_hold_cyc", tag), cycle_count, m_cyc);
  endtask

  task automatic finish_ok(input string tag, input bit we, input logic [4:0] wa,
                           input logic [31:0] wd);
    logic [NC-1:0] m;
    cyc(1, we, wa, wd, 1, TOHOST, 32'd1, 0);
    m = exp_mask();
    check($sformatf("%s_store_done", tag), done, 0);
    repeat (NC - 1) step();
    check($sformatf("%s_pre_done", tag), done, 0);
    step();
    verdict(tag, m == '0, (m == '0) ? 2'd0 : 2'd1, m);
  endtask

  task automatic finish_bad(input string tag, input logic [31:0] val);
    cyc(0, 0, 5'd0, 32'd0, 1, TOHOST, val, 0);
    verdict(tag, 0, 2'd2, '0);
  endtask

  task automatic finish_timeout(input string tag);
    while (m_cyc < TO - 1) cyc(1, 0, 5'd0, 32'd0, 0, 32'd0, 32'd0, 0);
    check($sformatf("%s_pre_done", tag), done, 0);
    cyc(1, 0, 5'd0, 32'd0, 0, 32'd0, 32'd0, 0);
    verdict(tag, 0, 2'd3, '0);
  endtask

  task automatic sum_prog();
    logic [31:0] s = 0;
    for (int i = 1; i <= 10; i++) begin
      s += 32'(i);
      cyc(1, 1, 5'd2, 32'(i), 0, 32'd0, 32'd0, 0);
      cyc(1, 1, 5'd3, s, 0, 32'd0, 32'd0, 0);
    end
    cyc(1, 1, 5'd1, s, 0, 32'd0, 32'd0, 0);
  endtask

  task automatic sum_slots(input logic [31:0] x3_exp);
    chk_en = 4'b0011;
    chk_reg = '0;
    chk_val = '0;
    chk_reg[4:0] = 5'd3;  chk_val[31:0]  = x3_exp;
    chk_reg[9:5] = 5'd1;  chk_val[63:32] = 32'd55;
  endtask

  initial begin
    repeat (2) step();
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_code", fail_code, 0);
    check("reset_mask", mismatch_mask, 0);
    check("reset_cyc", cycle_count, 0);
    check("reset_ret", retire_count, 0);
    rst = 0;

    start_run("t1"); sum_prog(); sum_slots(32'd55); finish_ok("t1", 0, 5'd0, 32'd0);
    check("t1_pass_const", pass, 1);

    start_run("t2"); sum_prog(); sum_slots(32'd54); finish_ok("t2", 0, 5'd0, 32'd0);
    check("t2_mask_const", mismatch_mask, 4'b0001);
    check("t2_code_const", fail_code, 2'd1);

    start_run("t3"); finish_timeout("t3");
    check("t3_cyc_const", cycle_count, 50);

    start_run("t4"); random_prog(5); finish_bad("t4", 32'd7);

    start_run("t5");
    cyc(1, 1, 5'd0, 32'd9, 0, 32'd0, 32'd0, 0);
    chk_en = 4'b0011; chk_reg = '0; chk_val = '0;
    chk_reg[9:5] = 5'd5; chk_val[63:32] = 32'd3;
    finish_ok("t5", 1, 5'd5, 32'd3);
    check("t5_pass_const", pass, 1);

    start_run("t6"); sum_prog(); sum_slots(32'd55);
    cyc(1, 0, 5'd0, 32'd0, 1, TOHOST, 32'd1, 0);
    step();
    rst = 1; step(); rst = 0;
    repeat (NC + 2) step();
    check("t6_rst_done", done, 0);
    check("t6_rst_code", fail_code, 0);
    check("t6_rst_cyc", cycle_count, 0);
    start_run("t6b"); sum_prog(); sum_slots(32'd55); finish_ok("t6b", 0, 5'd0, 32'd0);
    check("t6b_pass_const", pass, 1);

    // tohost=1 in the very cycle the timeout would fire: the store wins.
    start_run("prio"); random_prog(TO - 1); random_slots(0);
    finish_ok("prio", 0, 5'd0, 32'd0);

    for (int it = 0; it < 20; it++) begin
      string tg = $sformatf("rnd%0d", it);
      int kind = $urandom_range(0, 3);
      start_run(tg);
      random_prog($urandom_range(0, 30));
      case (kind)
        0: begin random_slots(0); finish_ok(tg, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom); end
        1: begin random_slots(1); finish_ok(tg, 0, 5'd0, 32'd0); end
        2: finish_bad(tg, 32'($urandom_range(2, 1000)));
        default: finish_timeout(tg);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
